// File: rtl/vector_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vector_fetch                                                  |
// | Purpose  : Frame-level fetch sequencer for the vector display path.      |
// |            Walks the display list through an external address counter   |
// |            (inc/zero) and a synchronous memory (rdata one cycle after    |
// |            the address), tracks the pen position and turns every         |
// |            beam-on word into a line segment for the downstream line      |
// |            drawer over a valid/ready handshake.                          |
// | Ports    : clk, rst (async, active-high)                                 |
// |            frame_start  - pulse, start walking the list from address 0   |
// |            count_adr    - current address counter value                  |
// |            rdata        - {eol, beam, x, y} word for previous address    |
// |            inc / zero   - address counter advance / clear                |
// |            seg_valid / seg_ready, seg_x0/y0/x1/y1 - segment handshake    |
// |            busy, frame_done (pulse), overrun (sticky per frame)          |
// | Options  : VFETCH_SKIPZERO_EN - drop zero-length draws (treated as move) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vector_fetch #(
   parameter int ADDRESSWIDTH = 10,
   parameter int COORDW       = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start,
   input  logic [ADDRESSWIDTH-1:0] count_adr,
   input  logic [2*COORDW+1:0]     rdata,
   output logic                    inc,
   output logic                    zero,
   output logic                    seg_valid,
   input  logic                    seg_ready,
   output logic [COORDW-1:0]       seg_x0,
   output logic [COORDW-1:0]       seg_y0,
   output logic [COORDW-1:0]       seg_x1,
   output logic [COORDW-1:0]       seg_y1,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    overrun
);

   localparam logic [ADDRESSWIDTH-1:0] C_TOP_ADR = {ADDRESSWIDTH{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ADDR  = 3'd2,
      S_FETCH = 3'd3,
      S_EMIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            r_state;
   logic [COORDW-1:0] r_px;
   logic [COORDW-1:0] r_py;

   logic              w_eol;
   logic              w_beam;
   logic [COORDW-1:0] w_x;
   logic [COORDW-1:0] w_y;
   logic              w_at_top;
   logic              w_zero_len;
   logic              w_draw;
   logic              w_advance;

   assign w_eol    = rdata[2*COORDW+1];
   assign w_beam   = rdata[2*COORDW];
   assign w_x      = rdata[2*COORDW-1:COORDW];
   assign w_y      = rdata[COORDW-1:0];
   assign w_at_top = (count_adr == C_TOP_ADR);

`ifdef VFETCH_SKIPZERO_EN
   assign w_zero_len = (w_x == r_px) && (w_y == r_py);
`else
   assign w_zero_len = 1'b0;
`endif

   // A draw word that actually produces a segment
   assign w_draw = w_beam && !w_zero_len;

   // The current non-eol word is finished with this cycle: a move decoded in
   // FETCH, or a segment handed off in EMIT.
   assign w_advance = ((r_state == S_FETCH) && !w_eol && !w_draw) ||
                      ((r_state == S_EMIT) && seg_ready);

   // inc must be decided in the same cycle the word is consumed so that the
   // counter shows the next address during the following ADDR cycle; it is
   // therefore the one output decoded from the current state and inputs.
   assign inc = w_advance && !w_at_top;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_px       <= '0;
         r_py       <= '0;
         zero       <= 1'b0;
         seg_valid  <= 1'b0;
         seg_x0     <= '0;
         seg_y0     <= '0;
         seg_x1     <= '0;
         seg_y1     <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         zero       <= 1'b0;
         frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  r_state <= S_CLEAR;
                  zero    <= 1'b1;
                  busy    <= 1'b1;
                  overrun <= 1'b0;
                  r_px    <= '0;
                  r_py    <= '0;
               end
            end
            S_CLEAR: begin
               r_state <= S_ADDR;
            end
            S_ADDR: begin
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (w_eol) begin
                  r_state    <= S_DONE;
                  frame_done <= 1'b1;
               end else begin
                  r_px <= w_x;
                  r_py <= w_y;
                  if (w_draw) begin
                     seg_x0    <= r_px;
                     seg_y0    <= r_py;
                     seg_x1    <= w_x;
                     seg_y1    <= w_y;
                     seg_valid <= 1'b1;
                     r_state   <= S_EMIT;
                  end else if (w_at_top) begin
                     overrun    <= 1'b1;
                     frame_done <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_state <= S_ADDR;
                  end
               end
            end
            S_EMIT: begin
               if (seg_ready) begin
                  seg_valid <= 1'b0;
                  if (w_at_top) begin
                     overrun    <= 1'b1;
                     frame_done <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_state <= S_ADDR;
                  end
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy      <= 1'b0;
               seg_valid <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vector_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vector_fetch                                               |
// | Purpose  : Self-checking bench for vector_fetch. Provides an address     |
// |            counter and synchronous display-list memory, a list-walking   |
// |            reference model, and a per-cycle compare process.             |
// | Options  : VFETCH_SKIPZERO_EN - model drops zero-length draws            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vector_fetch;

   localparam int AW = 3;
   localparam int CW = 10;
   localparam int DEPTH = 1 << AW;
`ifdef VFETCH_SKIPZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            frame_start;
   logic [AW-1:0]   count_adr;
   logic [2*CW+1:0] rdata;
   logic            inc, zero, seg_valid, seg_ready;
   logic [CW-1:0]   seg_x0, seg_y0, seg_x1, seg_y1;
   logic            busy, frame_done, overrun;

   vector_fetch #(.ADDRESSWIDTH(AW), .COORDW(CW)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .count_adr(count_adr),
      .rdata(rdata), .inc(inc), .zero(zero), .seg_valid(seg_valid),
      .seg_ready(seg_ready), .seg_x0(seg_x0), .seg_y0(seg_y0),
      .seg_x1(seg_x1), .seg_y1(seg_y1), .busy(busy),
      .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // External address counter and synchronous memory
   logic [2*CW+1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (rst) count_adr <= '0;
      else if (zero) count_adr <= '0;
      else if (inc) count_adr <= count_adr + 1'b1;
      rdata <= mem[count_adr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2*CW+1:0] word(input bit eol, input bit beam,
                                            input int x, input int y);
      logic [CW-1:0] xv, yv;
      xv = x[CW-1:0];
      yv = y[CW-1:0];
      return {eol, beam, xv, yv};
   endfunction

   // Reference model: walk the list with the display-list rules
   logic [4*CW-1:0] exp_q[$];
   int  exp_inc, exp_words;
   bit  exp_overrun;

   task automatic compute_model();
      logic [CW-1:0] px, py, x, y;
      exp_q.delete();
      exp_inc = 0; exp_words = 0; exp_overrun = 1'b0;
      px = '0; py = '0;
      for (int a = 0; a < DEPTH; a++) begin
         x = mem[a][2*CW-1:CW];
         y = mem[a][CW-1:0];
         exp_words++;
         if (mem[a][2*CW+1]) break;
         if (mem[a][2*CW] && !(SKIP && x == px && y == py))
            exp_q.push_back({px, py, x, y});
         px = x; py = y;
         if (a == DEPTH - 1) begin
            exp_overrun = 1'b1;
            break;
         end
         exp_inc++;
      end
   endtask

   // Per-cycle compare process
   bit  active = 0, first = 0, prev_stall = 0, ovr_hold = 0;
   logic [4*CW-1:0] prev_seg;
   int  incs, vcycles, dones, done_cyc, start_cyc;

   always @(negedge clk) begin
      if (rst) begin
         active = 0; first = 0; prev_stall = 0; ovr_hold = 0;
      end else begin
         check("busy", busy, active);
         check("zero", zero, first);
         check("inc_zero_excl", inc & zero, 0);
         if (frame_done) check("overrun_done", overrun, exp_overrun);
         else if (active) check("overrun_frame", overrun, 0);
         else check("overrun_idle", overrun, ovr_hold);
         if (prev_stall) begin
            check("stall_valid", seg_valid, 1);
            check("stall_hold", {seg_x0, seg_y0, seg_x1, seg_y1}, prev_seg);
         end
         if (inc) incs++;
         if (seg_valid) begin
            vcycles++;
            if (exp_q.size() == 0) check("seg_extra", seg_valid, 0);
            else check("seg_coords", {seg_x0, seg_y0, seg_x1, seg_y1}, exp_q[0]);
            if (!seg_ready) check("stall_inc", inc, 0);
            else if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         prev_stall = seg_valid && !seg_ready;
         prev_seg   = {seg_x0, seg_y0, seg_x1, seg_y1};
         first = 0;
         if (frame_done) begin
            dones++; done_cyc = cyc; ovr_hold = exp_overrun; active = 0;
         end else if (!active && frame_start) begin
            active = 1; first = 1; start_cyc = cyc;
         end
      end
   end

   // mode 0: ready high; 1: random ready; 2: ready low for 5 valid cycles
   task automatic run_frame(input int mode, input int spur);
      int vcnt;
      vcnt = 0;
      compute_model();
      incs = 0; vcycles = 0; dones = 0; done_cyc = 0; start_cyc = 0;
      @(posedge clk); #1;
      frame_start = 1'b1;
      seg_ready   = (mode == 0);
      for (int k = 0; k < 200 && dones == 0; k++) begin
         @(posedge clk); #1;
         frame_start = (k == spur) && busy;
         case (mode)
            0: seg_ready = 1'b1;
            1: seg_ready = ($urandom_range(0, 2) != 0);
            default: begin
               if (seg_valid) begin
                  seg_ready = (vcnt >= 5);
                  vcnt++;
               end else begin
                  seg_ready = 1'b0;
                  vcnt = 0;
               end
            end
         endcase
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      frame_start = 1'b0;
      check("done_cnt", dones, 1);
      check("inc_cnt", incs, exp_inc);
      check("segs_left", exp_q.size(), 0);
      check("frame_len", done_cyc - start_cyc, 2 + 2 * exp_words + vcycles);
      repeat (2) @(posedge clk);
      #1;
      check("done_once", dones, 1);
   endtask

   task automatic load_basic();
      for (int a = 0; a < DEPTH; a++) mem[a] = word(1, 0, 0, 0);
      mem[0] = word(0, 0, 10, 20);
      mem[1] = word(0, 1, 30, 40);
      mem[2] = word(1, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; seg_ready = 1'b0;
      for (int a = 0; a < DEPTH; a++) mem[a] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {inc, zero, seg_valid, busy, frame_done, overrun}, 0);
      check("rst_seg", {seg_x0, seg_y0, seg_x1, seg_y1}, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Basic list, ready held high
      load_basic();
      compute_model();
      check("model_t1_seg", exp_q[0], {10'd10, 10'd20, 10'd30, 10'd40});
      check("model_t1_inc", exp_inc, 2);
      run_frame(0, -1);
      check("t1_len", done_cyc - start_cyc, 9);
      check("t1_incs", incs, 2);
      check("t1_overrun", overrun, 0);

      // Same list with 5-cycle backpressure
      run_frame(2, -1);
      check("t2_hold_cycles", vcycles, 6);
      check("t2_incs", incs, 2);

      // Zero-length draw handling
      for (int a = 0; a < DEPTH; a++) mem[a] = word(1, 0, 0, 0);
      mem[0] = word(0, 1, 5, 5);
      mem[1] = word(0, 1, 5, 5);
      mem[2] = word(0, 1, 7, 9);
      compute_model();
      check("model_t3_nseg", exp_q.size(), SKIP ? 2 : 3);
      check("model_t3_last", exp_q[exp_q.size()-1], {10'd5, 10'd5, 10'd7, 10'd9});
      run_frame(0, 3);
      check("t3_segs", vcycles, SKIP ? 2 : 3);
      check("t3_incs", incs, 3);

      // Full list without eol: overrun
      for (int a = 0; a < DEPTH; a++) mem[a] = word(0, 0, a, a + 1);
      run_frame(0, 5);
      check("t5_incs", incs, 7);
      check("t5_overrun", overrun, 1);

      // Empty list; also clears the overrun from the previous frame
      mem[0] = word(1, 1, 3, 3);
      run_frame(0, 2);
      check("t4_len", done_cyc - start_cyc, 4);
      check("t4_incs", incs, 0);
      check("t4_segs", vcycles, 0);
      check("t4_overrun", overrun, 0);

      // Asynchronous reset while a segment is offered
      load_basic();
      compute_model();
      @(posedge clk); #1;
      frame_start = 1'b1;
      seg_ready   = 1'b0;
      @(posedge clk); #1;
      frame_start = 1'b0;
      for (int k = 0; k < 20 && !seg_valid; k++) begin
         @(posedge clk); #1;
      end
      check("rst_seg_seen", seg_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_ctrl", {inc, zero, seg_valid, busy, frame_done, overrun}, 0);
      check("async_rst_seg", {seg_x0, seg_y0, seg_x1, seg_y1}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);

      // Randomized lists
      for (int f = 0; f < 40; f++) begin
         int lx, ly;
         lx = 0; ly = 0;
         for (int a = 0; a < DEPTH; a++) begin
            bit e, b;
            e = ($urandom_range(0, 9) == 0);
            b = $urandom_range(0, 1);
            if ($urandom_range(0, 3) != 0) begin
               lx = $urandom_range(0, 1023);
               ly = $urandom_range(0, 1023);
            end
            mem[a] = word(e, b, lx, ly);
         end
         run_frame($urandom_range(0, 2), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 12) : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
